// File: rtl/spi_reg_pkg.sv
// Shared encodings for the SPI register bank: FSM states, command bit positions,
// and the filler byte returned when no read data is pending.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam int         CMD_W_BIT    = 7;
    localparam int         CMD_INC_BIT  = 6;
    localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_reg_bank_if.sv
// Byte handshake between the SPI slave byte engine (master side) and the
// register bank (slave side).
interface spi_reg_bank_if;

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_taken;

    modport master (
        output rx_byte,
        output rx_valid,
        output tx_taken,
        input  tx_byte
    );

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  tx_taken,
        output tx_byte
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a selectable
// value loaded on synchronous reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_bank.sv
// Command decoder and register file behind the SPI slave byte engine.
// Frames are delimited by the re-synchronised chip select.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no command yet in this frame; next rx byte is a command
// ST_WRITE | each rx byte is written to reg[ptr], ptr optionally advances
// ST_READ  | each tx_taken loads rd(ptr) into tx_byte, ptr optionally advances
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int STATUS_ADDR = 2**ADDR_W - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cs_n,
    spi_reg_bank_if.slave              bus,
    input  logic [7:0]                 status_in,
    output logic [(2**ADDR_W)*8-1:0]   regs_q,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 wr_data,
    output logic                       proto_err
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_ADDR);

    logic              cs_s;
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              inc;
    logic [7:0]        tx_q;
    logic [7:0]        mem [NUM_REGS];

    logic              cmd_w;
    logic              cmd_inc;
    logic              cmd_bad;
    logic [ADDR_W-1:0] cmd_addr;

    sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_s)
    );

    assign cmd_w    = bus.rx_byte[CMD_W_BIT];
    assign cmd_inc  = bus.rx_byte[CMD_INC_BIT];
    assign cmd_addr = bus.rx_byte[ADDR_W-1:0];
    // Reserved bits between the address field and INC must be zero.
    assign cmd_bad  = (bus.rx_byte[5:0] >> ADDR_W) != 6'd0;

    assign bus.tx_byte = tx_q;

    function automatic logic [7:0] rd(input logic [ADDR_W-1:0] a);
        return (a == STATUS_A) ? status_in : mem[a];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            inc       <= 1'b0;
            tx_q      <= TX_IDLE_BYTE;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (cs_s) begin
                state <= ST_IDLE;
                ptr   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_valid) begin
                            inc <= cmd_inc;
                            if (cmd_bad) proto_err <= 1'b1;
                            if (cmd_w) begin
                                state <= ST_WRITE;
                                ptr   <= cmd_addr;
                            end else begin
                                state <= ST_READ;
                                tx_q  <= rd(cmd_addr);
                                ptr   <= cmd_addr + ADDR_W'(cmd_inc);
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (bus.rx_valid) begin
                            if (ptr != STATUS_A) mem[ptr] <= bus.rx_byte;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= bus.rx_byte;
                            ptr       <= ptr + ADDR_W'(inc);
                        end
                        if (bus.tx_taken) tx_q <= TX_IDLE_BYTE;
                    end
                    ST_READ: begin
                        // Incoming bytes during a read are dummies clocked in by the master.
                        if (bus.tx_taken) begin
                            tx_q <= rd(ptr);
                            ptr  <= ptr + ADDR_W'(inc);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_q
        if (i == STATUS_ADDR) begin : g_status
            assign regs_q[i*8 +: 8] = 8'h00;
        end else begin : g_reg
            assign regs_q[i*8 +: 8] = mem[i];
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: committed writes are matched against a
// scoreboard queue; tx bytes, register contents and flags are checked directly.
module tb_spi_reg_bank;

    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2**ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cs_n;
    logic [7:0]            status_in;
    logic [NUM_REGS*8-1:0] regs_q;
    logic                  wr_strobe;
    logic [ADDR_W-1:0]     wr_addr;
    logic [7:0]            wr_data;
    logic                  proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr_seen = 0;
    int n_wr_exp  = 0;
    wr_exp_t wr_q[$];

    spi_reg_bank_if bus();

    spi_reg_bank #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .bus       (bus),
        .status_in (status_in),
        .regs_q    (regs_q),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_q[i*8 +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic take();
        bus.tx_taken = 1'b1;
        tick();
        bus.tx_taken = 1'b0;
    endtask

    task automatic cs_set(input logic v);
        cs_n = v;
        repeat (3) tick();
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_q.push_back('{addr: a, data: d});
        n_wr_exp++;
    endtask

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            wr_exp_t e;
            n_wr_seen++;
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                check_val("wr_addr", 32'(wr_addr), 32'(e.addr));
                check_val("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        cs_n         = 1'b1;
        status_in    = 8'h00;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_taken = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check_val("rst_tx", 32'(bus.tx_byte), 32'h00);
        check_val("rst_err", 32'(proto_err), 32'h0);
        check_val("rst_strobe", 32'(wr_strobe), 32'h0);
        check_val("rst_regs_lo", regs_q[31:0], 32'h0);
        check_val("rst_regs_hi", regs_q[127:96], 32'h0);

        // write burst with auto-increment
        cs_set(1'b0);
        expect_wr(4'd2, 8'h11); expect_wr(4'd3, 8'h22); expect_wr(4'd4, 8'h33);
        send_byte(8'hC2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        cs_set(1'b1);
        check_val("burst_r2", 32'(reg_at(2)), 32'h11);
        check_val("burst_r3", 32'(reg_at(3)), 32'h22);
        check_val("burst_r4", 32'(reg_at(4)), 32'h33);

        // write wrapping through the status location
        cs_set(1'b0);
        expect_wr(4'd14, 8'hAA); expect_wr(4'd15, 8'hBB); expect_wr(4'd0, 8'hCC);
        send_byte(8'hCE);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        cs_set(1'b1);
        check_val("wrap_r14", 32'(reg_at(14)), 32'hAA);
        check_val("wrap_r15", 32'(reg_at(15)), 32'h00);
        check_val("wrap_r0", 32'(reg_at(0)), 32'hCC);

        // read burst: reg14, status, reg0
        status_in = 8'h5A;
        cs_set(1'b0);
        send_byte(8'h4E);
        check_val("rd_lat1", 32'(bus.tx_byte), 32'hAA);
        take();
        check_val("rd_status", 32'(bus.tx_byte), 32'h5A);
        take();
        check_val("rd_wrap", 32'(bus.tx_byte), 32'hCC);
        send_byte(8'hFF);
        tick();
        check_val("rd_dummy", 32'(bus.tx_byte), 32'hCC);
        check_val("rd_dummy_err", 32'(proto_err), 32'h0);
        cs_set(1'b1);

        // non-incrementing read
        cs_set(1'b0);
        send_byte(8'h03);
        check_val("noinc_0", 32'(bus.tx_byte), 32'h22);
        for (int i = 0; i < 3; i++) begin
            take();
            check_val("noinc_n", 32'(bus.tx_byte), 32'h22);
        end
        cs_set(1'b1);

        // write frame: tx_taken returns the idle byte
        cs_set(1'b0);
        expect_wr(4'd5, 8'h66); expect_wr(4'd6, 8'h77);
        send_byte(8'hC5);
        check_val("wr_cmd_tx", 32'(bus.tx_byte), 32'h22);
        take();
        check_val("wr_take_tx", 32'(bus.tx_byte), 32'h00);
        send_byte(8'h66);
        send_byte(8'h77);
        cs_set(1'b1);
        check_val("wr_r5", 32'(reg_at(5)), 32'h66);
        check_val("wr_r6", 32'(reg_at(6)), 32'h77);

        // framing: abandoned write, byte while deselected, fresh command
        cs_set(1'b0);
        send_byte(8'h81);
        cs_set(1'b1);
        send_byte(8'h42);
        tick();
        check_val("cs_hi_ignore", 32'(bus.tx_byte), 32'h00);
        cs_set(1'b0);
        send_byte(8'h05);
        check_val("frame_rd5", 32'(bus.tx_byte), 32'h66);
        cs_set(1'b1);
        check_val("frame_r1", 32'(reg_at(1)), 32'h00);

        // protocol error is sticky across frames
        cs_set(1'b0);
        send_byte(8'h30);
        check_val("err_set", 32'(proto_err), 32'h1);
        check_val("err_rd0", 32'(bus.tx_byte), 32'hCC);
        cs_set(1'b1);
        cs_set(1'b0);
        send_byte(8'h01);
        check_val("err_sticky", 32'(proto_err), 32'h1);
        cs_set(1'b1);

        // reset in the middle of a write frame
        cs_set(1'b0);
        expect_wr(4'd1, 8'h99);
        send_byte(8'hC1);
        send_byte(8'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_val("mid_rst_err", 32'(proto_err), 32'h0);
        check_val("mid_rst_r1", 32'(reg_at(1)), 32'h00);
        check_val("mid_rst_r0", 32'(reg_at(0)), 32'h00);
        check_val("mid_rst_r14", 32'(reg_at(14)), 32'h00);
        check_val("mid_rst_tx", 32'(bus.tx_byte), 32'h00);
        expect_wr(4'd3, 8'h12);
        send_byte(8'h83);
        send_byte(8'h12);
        cs_set(1'b1);
        check_val("post_rst_r3", 32'(reg_at(3)), 32'h12);

        tick();
        check_val("wr_count", 32'(n_wr_seen), 32'(n_wr_exp));
        check_val("wr_q_left", 32'(wr_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
